// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter sharing the single register-file write port between NUM_REQ sources.
// Round-robin by default; define WB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [5*NUM_REQ-1:0]    req_rd,
    input  logic [XLEN*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    wb_stall,
    output logic [31:0]             rf_we,
    output logic [XLEN-1:0]         rf_wdata,
    output logic [4:0]              rf_waddr,
    output logic                    wb_valid,
    output logic [31:0]             wb_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [4:0]         sel_rd;
    logic [XLEN-1:0]    sel_data;
    int                 idx;

    // Walk offsets from the far end back towards rr_ptr so the closest valid requester
    // is the last one written and therefore wins, without needing a break or found flag.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        sel_rd    = '0;
        sel_data  = '0;
        idx       = 0;
        if (!rst && !wb_stall) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (req_valid[idx]) begin
                    grant          = '0;
                    grant[idx]     = 1'b1;
                    grant_idx      = PTR_W'(idx);
                    sel_rd         = req_rd[5*idx +: 5];
                    sel_data       = req_data[XLEN*idx +: XLEN];
                end
            end
        end
    end

    assign req_ready = grant;

`ifdef WB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [PTR_W-1:0] next_ptr;

    assign next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= next_ptr;
        end
    end
`endif

    // Bit 0 is masked so an accepted write to x0 still counts but never touches the regfile.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= '0;
            rf_wdata <= '0;
            rf_waddr <= '0;
            wb_valid <= 1'b0;
            wb_count <= '0;
        end else if (|grant) begin
            rf_we    <= (32'd1 << sel_rd) & 32'hFFFF_FFFE;
            rf_wdata <= sel_data;
            rf_waddr <= sel_rd;
            wb_valid <= 1'b1;
            wb_count <= wb_count + 32'd1;
        end else begin
            rf_we    <= '0;
            wb_valid <= 1'b0;
        end
    end

endmodule
